// File: rtl/i2c_poll_sequencer.sv
`timescale 1ns/1ps
// Polls one register of a fixed I2C slave by sequencing the master's controls.
// Captured bytes are strobed out; a missing ack raises a sticky error flag.
module i2c_poll_sequencer #(
    parameter logic [6:0] SLAVE_ADDR    = 7'b1110000,
    parameter logic [7:0] REG_ADDR      = 8'b10110010,
    parameter int         POLL_PERIOD   = 1024,
    parameter int         EN_SETUP      = 50,
    parameter int         ACKS_EXPECTED = 2,
    parameter int         ACK_TIMEOUT   = 512,
    parameter int         DATA_WAIT     = 200,
    parameter int         STOP_HOLD     = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auto_en,
    input  logic       trigger,
    output logic [6:0] address,
    output logic [7:0] register,
    output logic       mode,
    output logic       en,
    output logic       Start,
    output logic       Stop,
    output logic       repeat_start,
    input  logic       ack,
    input  logic [7:0] out,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       error,
    output logic       busy
);

    localparam int M0 = (POLL_PERIOD > EN_SETUP) ? POLL_PERIOD : EN_SETUP;
    localparam int M1 = (M0 > ACKS_EXPECTED) ? M0 : ACKS_EXPECTED;
    localparam int M2 = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
    localparam int M3 = (M2 > DATA_WAIT) ? M2 : DATA_WAIT;
    localparam int MX = (M3 > STOP_HOLD) ? M3 : STOP_HOLD;
    localparam int CW = $clog2(MX + 1);

    localparam logic [CW-1:0] L_SETUP = CW'(EN_SETUP - 1);
    localparam logic [CW-1:0] L_ACKS  = CW'(ACKS_EXPECTED - 1);
    localparam logic [CW-1:0] L_TMO   = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] L_DATA  = CW'(DATA_WAIT - 1);
    localparam logic [CW-1:0] L_STOP  = CW'(STOP_HOLD - 1);
    localparam logic [CW-1:0] L_POLL  = CW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_STOP,
        S_GAP
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [CW-1:0] r_timer, w_timer;
    logic [CW-1:0] r_ack_cnt, w_ack_cnt;
    logic          r_ack_q;
    logic [7:0]    r_data, w_data;
    logic          r_dv, w_dv;
    logic          r_err, w_err;
    logic          w_ack_rise;

    assign w_ack_rise = ack & ~r_ack_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_ack_cnt <= '0;
            r_ack_q   <= 1'b0;
            r_data    <= 8'h00;
            r_dv      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_timer   <= w_timer;
            r_ack_cnt <= w_ack_cnt;
            r_ack_q   <= ack;
            r_data    <= w_data;
            r_dv      <= w_dv;
            r_err     <= w_err;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_timer   = r_timer;
        w_ack_cnt = r_ack_cnt;
        w_data    = r_data;
        w_dv      = 1'b0;
        w_err     = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (auto_en || trigger) begin
                    w_state = S_SETUP;
                    w_cnt   = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == L_SETUP) begin
                    w_state   = S_START;
                    w_cnt     = '0;
                    w_err     = 1'b0;
                    w_ack_cnt = '0;
                    w_timer   = '0;
                end else begin
                    w_cnt = r_cnt + ONE;
                end
            end
            S_START: begin
                if (w_ack_rise) begin
                    w_ack_cnt = r_ack_cnt + ONE;
                    w_timer   = '0;
                    if (r_ack_cnt == L_ACKS) begin
                        w_state = S_WAIT;
                        w_cnt   = '0;
                    end
                end else if (r_timer == L_TMO) begin
                    w_state = S_STOP;
                    w_cnt   = '0;
                    w_err   = 1'b1;
                end else begin
                    w_timer = r_timer + ONE;
                end
            end
            S_WAIT: begin
                if (r_cnt == L_DATA) begin
                    w_state = S_STOP;
                    w_cnt   = '0;
                    w_data  = out;
                    w_dv    = 1'b1;
                end else begin
                    w_cnt = r_cnt + ONE;
                end
            end
            S_STOP: begin
                if (r_cnt == L_STOP) begin
                    w_state = S_GAP;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == L_POLL) begin
                    w_cnt = '0;
                    // Back-to-back polls keep en up, so SETUP is skipped.
                    if (auto_en) begin
                        w_state   = S_START;
                        w_err     = 1'b0;
                        w_ack_cnt = '0;
                        w_timer   = '0;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + ONE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    assign address      = SLAVE_ADDR;
    assign register     = REG_ADDR;
    assign mode         = 1'b0;
    assign repeat_start = 1'b0;
    assign en           = (r_state != S_IDLE);
    assign Start        = (r_state == S_START) || (r_state == S_WAIT);
    assign Stop         = (r_state == S_STOP);
    assign busy         = (r_state != S_IDLE) && (r_state != S_GAP);
    assign data         = r_data;
    assign data_valid   = r_dv;
    assign error        = r_err;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
`timescale 1ns/1ps
// Directed bench for i2c_poll_sequencer: manual, timeout, auto-poll, reset.
module tb_i2c_poll_sequencer;

    logic       clk;
    logic       rst_n;
    logic       auto_en;
    logic       trigger;
    logic [6:0] address;
    logic [7:0] register;
    logic       mode;
    logic       en;
    logic       Start;
    logic       Stop;
    logic       repeat_start;
    logic       ack;
    logic [7:0] out_b;
    logic [7:0] data;
    logic       data_valid;
    logic       error;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int dv_cnt = 0;
    int rise   = 0;
    int prev   = 0;
    logic start_q = 1'b0;

    i2c_poll_sequencer dut (
        .clk         (clk),
        .reset       (rst_n),
        .auto_en     (auto_en),
        .trigger     (trigger),
        .address     (address),
        .register    (register),
        .mode        (mode),
        .en          (en),
        .Start       (Start),
        .Stop        (Stop),
        .repeat_start(repeat_start),
        .ack         (ack),
        .out         (out_b),
        .data        (data),
        .data_valid  (data_valid),
        .error       (error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) dv_cnt <= dv_cnt + 1;
        if (Start && !start_q) begin
            prev <= rise;
            rise <= cyc;
        end
        start_q <= Start;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ends one cycle after Start rises.
    task automatic start_manual();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        chk("setup_en", en, 1);
        chk("setup_busy", busy, 1);
        chk("setup_nostart", Start, 0);
        tick(49);
        chk("setup_hold", Start, 0);
        tick(1);
        chk("start_rise", Start, 1);
        chk("start_nostop", Stop, 0);
    endtask

    // From Start rise S: acks at S+100 and S+300, ends at S+500.
    task automatic run_good(input logic [7:0] ov, input bit trig,
                            input bit noise);
        out_b   = ov;
        trigger = trig;
        tick(1);
        trigger = 1'b0;
        tick(98);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(197);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(48);
        ack = noise;
        tick(2);
        ack = 1'b0;
        tick(147);
        chk("dv_early", data_valid, 0);
        chk("wait_start", Start, 1);
        tick(1);
        chk("dv_pulse", data_valid, 1);
        chk("data_val", data, {24'h0, ov});
        chk("stop_rise", Stop, 1);
        chk("start_fall", Start, 0);
        chk("err_good", error, 0);
    endtask

    // From S+500 through STOP and GAP into IDLE at S+1624.
    task automatic to_idle(input bit noise);
        tick(1);
        chk("dv_once", data_valid, 0);
        tick(98);
        chk("stop_hold", Stop, 1);
        tick(1);
        chk("stop_fall", Stop, 0);
        chk("gap_en", en, 1);
        chk("gap_busy", busy, 0);
        if (noise) begin
            ack = 1'b1;
            tick(2);
            ack = 1'b0;
            trigger = 1'b1;
            tick(1);
            trigger = 1'b0;
            tick(1020);
        end else begin
            tick(1023);
        end
        chk("gap_end_en", en, 1);
        tick(1);
        chk("idle_en_off", en, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n   = 1'b1;
        auto_en = 1'b0;
        trigger = 1'b0;
        ack     = 1'b0;
        out_b   = 8'h00;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_en", en, 0);
        chk("rst_start", Start, 0);
        chk("rst_stop", Stop, 0);
        chk("rst_data", data, 8'h00);
        chk("rst_dv", data_valid, 0);
        chk("rst_err", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", address, 7'h70);
        chk("rst_reg", register, 8'hB2);
        chk("rst_mode", mode, 0);
        chk("rst_rs", repeat_start, 0);
        #21 rst_n = 1'b1;
        tick(3);
        chk("idle_stay", en, 0);

        // Manual read
        start_manual();
        run_good(8'hF0, 1'b0, 1'b0);
        to_idle(1'b0);
        chk("dv_cnt_man", dv_cnt, 1);

        // Timeout after a single ack
        start_manual();
        out_b = 8'h99;
        tick(99);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(509);
        chk("tmo_nostop", Stop, 0);
        chk("tmo_start", Start, 1);
        chk("tmo_noerr", error, 0);
        tick(1);
        chk("tmo_stop", Stop, 1);
        chk("tmo_sfall", Start, 0);
        chk("tmo_err", error, 1);
        chk("tmo_data", data, 8'hF0);
        chk("tmo_dv", data_valid, 0);
        tick(99);
        chk("tmo_hold", Stop, 1);
        tick(1);
        chk("tmo_sfall2", Stop, 0);
        tick(1024);
        chk("tmo_idle", en, 0);
        chk("tmo_sticky", error, 1);
        chk("dv_cnt_tmo", dv_cnt, 1);

        // Error clears at Start; trigger and ack noise ignored
        start_manual();
        chk("err_clr", error, 0);
        run_good(8'h3C, 1'b1, 1'b1);
        to_idle(1'b1);
        tick(100);
        chk("no_queue_en", en, 0);
        chk("no_queue_busy", busy, 0);
        chk("dv_cnt_clr", dv_cnt, 2);

        // Auto polling, auto_en dropped during the third read
        auto_en = 1'b1;
        tick(1);
        chk("auto_en", en, 1);
        tick(49);
        chk("auto_setup", Start, 0);
        tick(1);
        chk("auto_start", Start, 1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) auto_en = 1'b0;
            run_good(8'(8'h10 + k), 1'b0, 1'b0);
            if (k > 0) chk("poll_space", rise - prev, 1624);
            if (k < 2) begin
                tick(1123);
                chk("gap_nostart", Start, 0);
                chk("gap_en_hold", en, 1);
                chk("gap_notbusy", busy, 0);
                tick(1);
                chk("poll_start", Start, 1);
                chk("poll_busy", busy, 1);
            end
        end
        to_idle(1'b0);
        chk("dv_cnt_auto", dv_cnt, 5);

        // Asynchronous reset inside WAIT_DATA
        start_manual();
        out_b = 8'hAA;
        tick(99);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(197);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(50);
        chk("mid_busy", busy, 1);
        chk("mid_start", Start, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_start", Start, 0);
        chk("arst_stop", Stop, 0);
        chk("arst_en", en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", data, 8'h00);
        chk("arst_dv", data_valid, 0);
        chk("arst_err", error, 0);
        #20 rst_n = 1'b1;
        tick(2);
        chk("post_rst_en", en, 0);
        chk("post_rst_data", data, 8'h00);
        chk("dv_cnt_rst", dv_cnt, 5);
        start_manual();
        run_good(8'h5A, 1'b0, 1'b0);
        to_idle(1'b0);
        chk("dv_cnt_end", dv_cnt, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
